// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared types and helpers for the pipelined FP multiplier.
//   fp_class_e  operand / result class (ZERO, NORM, INF, NAN)
//   bias()      exponent bias for a given exponent width
//   canon_nan() canonical quiet NaN {0, all-ones exp, fraction MSB set},
//               right-aligned in 64 bits; callers cast down to their width.
package fp_mult_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_mult_round.sv
// fp_mult_round: final stage of the multiplier (combinational).
// Normalises the significand product, rounds, renormalises on carry-out,
// detects overflow/underflow, applies special-case results and packs.
//   sign_i, cls_i   result sign and class decided at unpack time
//   e_i             biased exponent sum (EXP_W+2 bits, two's complement)
//   prod_i          (1.ma)*(1.mb), 2*(MAN_W+1) bits
//   product_o       packed result; *_o flags as in the top-level header
// Rounding: ROUND_NEAREST_EN defined -> nearest/ties-to-even, else truncate.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W,
  localparam int PW   = 2 * (MAN_W + 1)
) (
  input  logic             sign_i,
  input  fp_class_e        cls_i,
  input  logic [EXP_W+1:0] e_i,
  input  logic [PW-1:0]    prod_i,
  output logic [W-1:0]     product_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             infinity_o,
  output logic             nan_o,
  output logic             inexact_o
);

  localparam logic [W-1:0] NAN_W = W'(canon_nan(EXP_W, MAN_W));

  logic             hi;
  logic [PW-2:0]    norm;      // product with the leading one dropped
  logic [MAN_W-1:0] frac;
  logic             guard, sticky, rnd_up;
  logic [MAN_W:0]   frac_sum;
  logic [EXP_W+1:0] e_adj;
  logic             ovf, unf;

  // Product lies in [1,4); bit PW-1 set means [2,4) and costs one exponent step.
  assign hi     = prod_i[PW-1];
  assign norm   = hi ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
  assign frac   = norm[PW-2 -: MAN_W];
  assign guard  = norm[MAN_W];
  assign sticky = |norm[MAN_W-1:0];

`ifdef ROUND_NEAREST_EN
  assign rnd_up = guard & (sticky | frac[0]);
`else
  assign rnd_up = 1'b0;
`endif

  // Carry-out leaves the fraction all-zero, so renormalising is just e+1.
  assign frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
  assign e_adj    = e_i + {{(EXP_W+1){1'b0}}, hi} + {{(EXP_W+1){1'b0}}, frac_sum[MAN_W]};

  assign ovf = !e_adj[EXP_W+1] && (e_adj[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
  assign unf = e_adj[EXP_W+1] || (e_adj == '0);

  always_comb begin
    product_o   = {sign_i, e_adj[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    infinity_o  = 1'b0;
    nan_o       = 1'b0;
    inexact_o   = 1'b0;
    case (cls_i)
      NAN: begin
        product_o = NAN_W;
        nan_o     = 1'b1;
      end
      INF: begin
        product_o  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        infinity_o = 1'b1;
      end
      ZERO: product_o = {sign_i, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          product_o  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          overflow_o = 1'b1;
          infinity_o = 1'b1;
          inexact_o  = 1'b1;
        end else if (unf) begin
          product_o   = {sign_i, {(W-1){1'b0}}};
          underflow_o = 1'b1;
          inexact_o   = 1'b1;
        end else begin
          inexact_o = guard | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier, valid/ready.
//   clk, rst (async, active high)
//   in_valid/in_ready, a, b            operand handshake
//   out_valid/out_ready, product       result handshake
//   overflow, underflow, infinity, nan, inexact  flags, valid with out_valid
// Stages: S1 unpack/classify/exponent sum, S2 significand multiply,
// S3 normalise/round/pack (fp_mult_round). The whole pipe advances together
// when the output is empty or being taken; bubbles are not collapsed.
// Optional macro: ROUND_NEAREST_EN selects round-to-nearest-even (else truncate).
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W,
  localparam int PW   = 2 * (MAN_W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         overflow,
  output logic         underflow,
  output logic         infinity,
  output logic         nan,
  output logic         inexact
);

  localparam int             BIAS   = bias(EXP_W);
  localparam logic [EXP_W+1:0] BIAS_V = BIAS[EXP_W+1:0];

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    fp_class_e        cls;
  } op_t;

  // Subnormals (exp==0) are classed as zero.
  function automatic op_t unpack(input logic [W-1:0] x);
    op_t o;
    o.sign = x[W-1];
    o.exp  = x[W-2 -: EXP_W];
    o.sig  = {1'b1, x[MAN_W-1:0]};
    if (o.exp == '0)  o.cls = ZERO;
    else if (&o.exp)  o.cls = (x[MAN_W-1:0] != '0) ? NAN : INF;
    else              o.cls = NORM;
    return o;
  endfunction

  logic [2:0] vld_q;
  logic       adv;

  op_t              ua, ub;
  logic             s1_sign_d, s1_sign_q, s2_sign_q;
  fp_class_e        s1_cls_d, s1_cls_q, s2_cls_q;
  logic [EXP_W+1:0] s1_e_d, s1_e_q, s2_e_q;
  logic [MAN_W:0]   s1_siga_q, s1_sigb_q;
  logic [PW-1:0]    s2_prod_d, s2_prod_q;

  logic [W-1:0] product_d, product_q;
  logic [4:0]   flags_d, flags_q;   // {overflow, underflow, infinity, nan, inexact}

  assign adv      = !vld_q[2] | out_ready;
  assign in_ready = adv;

  // S1: unpack and resolve the special-case result class by priority.
  always_comb begin
    ua        = unpack(a);
    ub        = unpack(b);
    s1_sign_d = ua.sign ^ ub.sign;
    s1_e_d    = {2'b00, ua.exp} + {2'b00, ub.exp} - BIAS_V;
    if (ua.cls == NAN || ub.cls == NAN ||
        (ua.cls == INF && ub.cls == ZERO) || (ua.cls == ZERO && ub.cls == INF))
      s1_cls_d = NAN;
    else if (ua.cls == INF || ub.cls == INF)
      s1_cls_d = INF;
    else if (ua.cls == ZERO || ub.cls == ZERO)
      s1_cls_d = ZERO;
    else
      s1_cls_d = NORM;
  end

  // S2: full-width significand product.
  assign s2_prod_d = s1_siga_q * s1_sigb_q;

  fp_mult_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign_i      (s2_sign_q),
    .cls_i       (s2_cls_q),
    .e_i         (s2_e_q),
    .prod_i      (s2_prod_q),
    .product_o   (product_d),
    .overflow_o  (flags_d[4]),
    .underflow_o (flags_d[3]),
    .infinity_o  (flags_d[2]),
    .nan_o       (flags_d[1]),
    .inexact_o   (flags_d[0])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= ZERO;
      s1_e_q    <= '0;
      s1_siga_q <= '0;
      s1_sigb_q <= '0;
      s2_sign_q <= 1'b0;
      s2_cls_q  <= ZERO;
      s2_e_q    <= '0;
      s2_prod_q <= '0;
      product_q <= '0;
      flags_q   <= '0;
    end else if (adv) begin
      vld_q     <= {vld_q[1:0], in_valid};
      s1_sign_q <= s1_sign_d;
      s1_cls_q  <= s1_cls_d;
      s1_e_q    <= s1_e_d;
      s1_siga_q <= ua.sig;
      s1_sigb_q <= ub.sig;
      s2_sign_q <= s1_sign_q;
      s2_cls_q  <= s1_cls_q;
      s2_e_q    <= s1_e_q;
      s2_prod_q <= s2_prod_d;
      product_q <= product_d;
      flags_q   <= flags_d;
    end
  end

  assign out_valid = vld_q[2];
  assign product   = product_q;
  assign overflow  = flags_q[4];
  assign underflow = flags_q[3];
  assign infinity  = flags_q[2];
  assign nan       = flags_q[1];
  assign inexact   = flags_q[0];

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed test of fp_mult_pipe (binary32 defaults).
// Single operations with latency/flag checks, a stalled 6-op stream, and
// a mid-stream reset. Flags are compared as {ovf, unf, inf, nan, inx}.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, product;
  logic        overflow, underflow, infinity, nan, inexact;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .underflow (underflow),
    .infinity  (infinity),
    .nan       (nan),
    .inexact   (inexact)
  );

  function automatic logic [4:0] flags();
    return {overflow, underflow, infinity, nan, inexact};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation through an idle pipe; latency counted in cycles from the accept cycle.
  task automatic single(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ep, input logic [4:0] ef);
    int lat;
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd3);
    check({tag, " product"}, 64'(product), 64'(ep));
    check({tag, " flags"}, 64'(flags()), 64'(ef));
    @(posedge clk); #1;
    check({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] sa [6];
  logic [31:0] sb [6];
  logic [31:0] sp [6];
  logic [31:0] got[6];
  logic [31:0] rnd_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, i, cyc, vcnt;
    logic acc, saw_stall, held_v;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", 64'(product), 64'd0);
    check("reset flags", 64'(flags()), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    single("mul85x45",  32'h42AA4000, 32'h42348000, 32'h45701440, 5'b00000);
    single("negxneg",   32'hC0B00000, 32'hC1280000, 32'h42670000, 5'b00000);
    single("onexmone",  32'h3F800000, 32'hBF800000, 32'hBF800000, 5'b00000);
    single("xzero",     32'h42AA4000, 32'h00000000, 32'h00000000, 5'b00000);
    single("infxzero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b00010);
    single("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b10101);
    single("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 5'b01001);
    single("ninfx2",    32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00100);
    single("nanin",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00010);
`ifdef ROUND_NEAREST_EN
    rnd_exp = 32'h40400002;
`else
    rnd_exp = 32'h40400001;
`endif
    single("rounding",  32'h3F800001, 32'h40400000, rnd_exp, 5'b00001);

    // Stream of 6 with out_ready low during cycles 4..8.
    sa[0] = 32'h42AA4000; sb[0] = 32'h42348000; sp[0] = 32'h45701440;
    sa[1] = 32'hC0B00000; sb[1] = 32'hC1280000; sp[1] = 32'h42670000;
    sa[2] = 32'h3F800000; sb[2] = 32'hBF800000; sp[2] = 32'hBF800000;
    sa[3] = 32'h42AA4000; sb[3] = 32'h00000000; sp[3] = 32'h00000000;
    sa[4] = 32'h7F800000; sb[4] = 32'h00000000; sp[4] = 32'h7FC00000;
    sa[5] = 32'h7F000000; sb[5] = 32'h7F000000; sp[5] = 32'h7F800000;
    n = 0; i = 0; cyc = 0; saw_stall = 1'b0; held_v = 1'b0; held = '0;
    while (n < 6 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (i < 6);
      a = sa[i < 6 ? i : 5];
      b = sb[i < 6 ? i : 5];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready && n < 6) begin
        got[n] = product;
        n++;
      end
      if (out_valid && !out_ready) begin
        if (held_v) check("stall stable", 64'(product), 64'(held));
        held = product; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream count", 64'(n), 64'd6);
    check("stream in_ready dropped", 64'(saw_stall), 64'd1);
    for (int k = 0; k < 6; k++)
      if (k < n) check($sformatf("stream result %0d", k), 64'(got[k]), 64'(sp[k]));
    @(posedge clk); #1;
    check("stream no extra", 64'(out_valid), 64'd0);

    // Reset with results in flight.
    for (int k = 0; k < 4; k++) begin
      a = sa[k]; b = sb[k]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset product", 64'(product), 64'd0);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    check("post reset no output", 64'(vcnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
